pixel_scan_engine: RTL

- Datapath stage directly downstream of the processing controller.
- Consumes the controller's `enable` level and returns the `done` it waits on.
- While enabled, scans every destination pixel once, fetches the mapped source pixel from source image memory, and writes it to destination memory.
- Supported mappings: copy, nearest-neighbour zoom x2, decimate /2. Throughput is one pixel per clock.

---
 rtl/pixel_pkg.sv | 30 +++
 rtl/pixel_scan_engine_raster_counter.sv | 36 +++
 rtl/pixel_scan_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared mode/state encodings and destination-size helper for the pixel scan engine.
// Pure declarations; no logic of its own.
package pixel_pkg;

    localparam logic [1:0] MODE_COPY = 2'b00;
    localparam logic [1:0] MODE_ZOOM = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] h;
    } dims_t;

    // Mode 11 falls through to copy dimensions.
    function automatic dims_t dst_dims(input logic [1:0] mode, input int src_w, input int src_h);
        dims_t d;
        case (mode)
            MODE_ZOOM: begin d.w = 16'(src_w * 2); d.h = 16'(src_h * 2); end
            MODE_DEC:  begin d.w = 16'(src_w / 2); d.h = 16'(src_h / 2); end
            default:   begin d.w = 16'(src_w);     d.h = 16'(src_h);     end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pixel_scan_engine_raster_counter.sv
// Raster x/y scan counter: x fastest, wraps at limit_x; last flags (limit_x, limit_y).
// Advances one position per step; clr has priority; last is combinational.
module raster_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         step,
    input  logic [W-1:0] limit_x,
    input  logic [W-1:0] limit_y,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         last
);

    assign last = (x == limit_x) && (y == limit_y);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (x == limit_x) begin
                x <= '0;
                y <= last ? '0 : y + W'(1);
            end else begin
                x <= x + W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_scan_engine.sv
// Scans destination pixels, reads mapped source pixel, writes it out; 1 pixel/clk.
// Write lags read by RD_LAT cycles; dropping enable aborts and flushes in-flight writes.
module pixel_scan_engine
    import pixel_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [RD_LAT-1:0] OUT_BIT = RD_LAT'(1) << (RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        mode_q;
    dims_t             dims;
    logic [ADDR_W-1:0] dw, dh, dx, dy, sx, sy, di;
    logic              clr, step, last, abort;
    logic [RD_LAT-1:0] pv;
    logic [ADDR_W-1:0] pa [RD_LAT];

    assign dims  = dst_dims(mode_q, SRC_W, SRC_H);
    assign dw    = ADDR_W'(dims.w);
    assign dh    = ADDR_W'(dims.h);

    assign busy  = (state == S_SCAN) || (state == S_DRAIN);
    assign done  = (state == S_DONE);
    assign abort = busy && !enable;
    assign clr   = (state == S_IDLE) && enable;
    assign step  = (state == S_SCAN) && enable;

    raster_counter #(.W(ADDR_W)) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .step    (step),
        .limit_x (dw - ADDR_W'(1)),
        .limit_y (dh - ADDR_W'(1)),
        .x       (dx),
        .y       (dy),
        .last    (last)
    );

    always_comb begin
        sx = dx;
        sy = dy;
        case (mode_q)
            MODE_ZOOM: begin sx = dx >> 1; sy = dy >> 1; end
            MODE_DEC:  begin sx = dx << 1; sy = dy << 1; end
            default:   ;
        endcase
    end

    assign rd_en   = step;
    assign rd_addr = rd_en ? (sy * ADDR_W'(SRC_W) + sx) : '0;

    // Enable gates the write strobe so an abort suppresses the write in its own cycle.
    assign wr_en   = pv[RD_LAT-1] && enable;
    assign wr_addr = wr_en ? pa[RD_LAT-1] : '0;
    assign wr_data = wr_en ? rd_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            mode_q <= MODE_COPY;
            di     <= '0;
        end else begin
            if (clr)
                di <= '0;
            else if (step)
                di <= di + ADDR_W'(1);
            case (state)
                S_IDLE: if (enable) begin
                    mode_q <= mode;
                    state  <= S_SCAN;
                end
                S_SCAN: begin
                    if (!enable)
                        state <= S_IDLE;
                    else if (last)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!enable)
                        state <= S_IDLE;
                    else if ((pv & ~OUT_BIT) == '0)
                        state <= S_DONE;
                end
                S_DONE: if (!enable) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Destination index rides alongside the read through RD_LAT stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++)
                pa[i] <= '0;
        end else if (abort) begin
            pv <= '0;
        end else begin
            pv[0] <= rd_en;
            pa[0] <= di;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

endmodule
